// File: rtl/spi_controller_if.sv
// Request-side handshake bundle for spi_controller: one register write per valid/ready transfer.
interface spi_controller_if;
  logic       req_valid;
  logic       req_ready;
  logic [6:0] req_addr;
  logic [7:0] req_data;
  logic       busy;
  logic       done;

  modport master (
    output req_valid,
    output req_addr,
    output req_data,
    input  req_ready,
    input  busy,
    input  done
  );

  modport slave (
    input  req_valid,
    input  req_addr,
    input  req_data,
    output req_ready,
    output busy,
    output done
  );
endinterface

// File: rtl/spi_controller.sv
// Mode-0, write-only SPI master emitting 16-bit {1'b1, addr, data} frames, MSB first.
module spi_controller #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  spi_controller_if.slave  req,
  output logic             sclk,
  output logic             cs_n,
  output logic             copi
);

  // copi must outlast the peripheral's 2-FF synchronizer.
  if (CLK_DIV < 4) begin : g_bad_clk_div
    $error("spi_controller: CLK_DIV must be >= 4");
  end

  localparam int unsigned CntW = $clog2(CLK_DIV);
  localparam logic [CntW-1:0] CntLast = CntW'(CLK_DIV - 1);
  localparam logic [CntW-1:0] GapLast = CntW'(CLK_DIV - 2);

  typedef enum logic [2:0] {StIdle, StLead, StHigh, StLow, StLag, StGap} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] div_q, div_d;
  logic [3:0]      bit_q, bit_d;
  logic [15:0]     shreg_q, shreg_d;
  logic            sclk_q, sclk_d;
  logic            cs_n_q, cs_n_d;
  logic            copi_q, copi_d;
  logic            ready_q, ready_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            phase_end;

  assign phase_end = (div_q == CntLast);

  always_comb begin
    state_d  = state_q;
    div_d    = div_q + 1'b1;
    bit_d    = bit_q;
    shreg_d  = shreg_q;
    sclk_d   = sclk_q;
    cs_n_d   = cs_n_q;
    copi_d   = copi_q;
    ready_d  = ready_q;
    done_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        div_d = '0;
        if (req.req_valid && ready_q) begin
          state_d = StLead;
          shreg_d = {1'b1, req.req_addr, req.req_data};
          bit_d   = '0;
          cs_n_d  = 1'b0;
          copi_d  = 1'b1;
          ready_d = 1'b0;
        end
      end
      StLead: begin
        if (phase_end) begin
          state_d = StHigh;
          sclk_d  = 1'b1;
          div_d   = '0;
        end
      end
      StHigh: begin
        if (phase_end) begin
          sclk_d = 1'b0;
          div_d  = '0;
          if (bit_q == 4'd15) begin
            state_d = StLag;
          end else begin
            state_d = StLow;
            // Rotate rather than shift; the register is reloaded on every accept anyway.
            shreg_d = {shreg_q[14:0], shreg_q[15]};
            copi_d  = shreg_q[14];
            bit_d   = bit_q + 4'd1;
          end
        end
      end
      StLow: begin
        if (phase_end) begin
          state_d = StHigh;
          sclk_d  = 1'b1;
          div_d   = '0;
        end
      end
      StLag: begin
        if (phase_end) begin
          state_d = StGap;
          cs_n_d  = 1'b1;
          copi_d  = 1'b0;
          done_d  = 1'b1;
          bit_d   = bit_q + 4'd1;
          div_d   = '0;
        end
      end
      StGap: begin
        // Ends one cycle early: the IDLE cycle completes the CLK_DIV-cycle gap, so a held
        // request is accepted exactly 34*CLK_DIV cycles after the previous one.
        if (div_q == GapLast) begin
          state_d = StIdle;
          ready_d = 1'b1;
          div_d   = '0;
        end
      end
      default: begin
        state_d = StIdle;
        ready_d = 1'b1;
        cs_n_d  = 1'b1;
        sclk_d  = 1'b0;
        copi_d  = 1'b0;
        div_d   = '0;
      end
    endcase

    busy_d = ~ready_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      div_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      sclk_q  <= 1'b0;
      cs_n_q  <= 1'b1;
      copi_q  <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      sclk_q  <= sclk_d;
      cs_n_q  <= cs_n_d;
      copi_q  <= copi_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign sclk          = sclk_q;
  assign cs_n          = cs_n_q;
  assign copi          = copi_q;
  assign req.req_ready = ready_q;
  assign req.busy      = busy_q;
  assign req.done      = done_q;

endmodule

// File: tb/tb_spi_controller.sv
// Directed bench for spi_controller: CLK_DIV=4 and CLK_DIV=6 instances share clk/rst_n.
module tb_spi_controller;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  spi_controller_if bus4 ();
  spi_controller_if bus6 ();

  logic sclk4, cs_n4, copi4, sclk6, cs_n6, copi6;

  spi_controller #(.CLK_DIV(4)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (bus4),
    .sclk  (sclk4),
    .cs_n  (cs_n4),
    .copi  (copi4)
  );

  spi_controller #(.CLK_DIV(6)) dut6 (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (bus6),
    .sclk  (sclk6),
    .cs_n  (cs_n6),
    .copi  (copi6)
  );

  logic sclk_w[2], cs_w[2], copi_w[2], ready_w[2], busy_w[2], done_w[2];
  assign sclk_w[0]  = sclk4;          assign sclk_w[1]  = sclk6;
  assign cs_w[0]    = cs_n4;          assign cs_w[1]    = cs_n6;
  assign copi_w[0]  = copi4;          assign copi_w[1]  = copi6;
  assign ready_w[0] = bus4.req_ready; assign ready_w[1] = bus6.req_ready;
  assign busy_w[0]  = bus4.busy;      assign busy_w[1]  = bus6.busy;
  assign done_w[0]  = bus4.done;      assign done_w[1]  = bus6.done;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Line monitor: all times are cycles after the edge where cs_n fell (the accept edge).
  int          e0[2], accepts[2], rises[2], frames[2], cs_low[2], cs_high[2], cs_rise_t[2];
  int          acc_gap[2], done_cnt[2], done_t[2], stray[2], sclk_tog[2];
  int          rise_t[2][16];
  logic [15:0] frame[2];
  logic [15:0] frame_log[2][8];
  logic        sclk_p[2], cs_p[2];

  initial begin
    for (int d = 0; d < 2; d++) begin
      e0[d] = 0; accepts[d] = 0; rises[d] = 0; frames[d] = 0; cs_low[d] = 0;
      cs_high[d] = 0; cs_rise_t[d] = 0; acc_gap[d] = 0; done_cnt[d] = 0; done_t[d] = 0;
      stray[d] = 0; sclk_tog[d] = 0; frame[d] = '0; sclk_p[d] = 1'b0; cs_p[d] = 1'b1;
    end
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (sclk_w[d] !== sclk_p[d]) begin
          sclk_tog[d]++;
          if (cs_w[d] && cs_p[d]) stray[d]++;
        end
        if (cs_p[d] && !cs_w[d]) begin
          if (accepts[d] > 0) acc_gap[d] = cyc - e0[d];
          cs_high[d] = cyc - cs_rise_t[d];
          e0[d] = cyc;
          accepts[d]++;
          rises[d] = 0;
          frame[d] = '0;
        end
        if (!sclk_p[d] && sclk_w[d]) begin
          frame[d] = {frame[d][14:0], copi_w[d]};
          if (rises[d] < 16) rise_t[d][rises[d]] = cyc - e0[d];
          rises[d]++;
        end
        if (!cs_p[d] && cs_w[d]) begin
          cs_low[d] = cyc - e0[d];
          frame_log[d][frames[d] % 8] = frame[d];
          frames[d]++;
          cs_rise_t[d] = cyc;
        end
        if (done_w[d]) begin
          done_cnt[d]++;
          done_t[d] = cyc - e0[d];
        end
        sclk_p[d] = sclk_w[d];
        cs_p[d]   = cs_w[d];
      end
    end
  end

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic wait_ready(input int d, input logic lvl, input int budget, input string tag);
    int n = 0;
    while (ready_w[d] !== lvl && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, ready_w[d], lvl);
  endtask

  task automatic wait_frames(input int d, input int target, input int budget, input string tag);
    int n = 0;
    while (frames[d] < target && n < budget) begin
      @(posedge clk);
      n++;
    end
    check_eq(tag, frames[d], target);
  endtask

  int t0, nf, na, nd;

  initial begin
    bus4.req_valid = 1'b0; bus4.req_addr = '0; bus4.req_data = '0;
    bus6.req_valid = 1'b0; bus6.req_addr = '0; bus6.req_data = '0;

    // Reset values and quiet sclk while held in reset.
    repeat (3) @(negedge clk);
    check_eq("rst_cs_n", cs_n4, 1'b1);
    check_eq("rst_sclk", sclk4, 1'b0);
    check_eq("rst_copi", copi4, 1'b0);
    check_eq("rst_ready", bus4.req_ready, 1'b1);
    check_eq("rst_busy", bus4.busy, 1'b0);
    check_eq("rst_done", bus4.done, 1'b0);
    repeat (20) @(negedge clk);
    @(posedge clk);
    check_eq("rst_no_sclk_edges", sclk_tog[0] + sclk_tog[1], 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single write 0x02/0xA5 -> 0x82A5.
    nd = done_cnt[0];
    bus4.req_valid = 1'b1; bus4.req_addr = 7'h02; bus4.req_data = 8'hA5;
    @(negedge clk);
    bus4.req_valid = 1'b0; bus4.req_addr = '0; bus4.req_data = '0;
    @(posedge clk);
    check_eq("single_accepted", accepts[0], 1);
    t0 = e0[0];
    wait_until(t0 + 1);
    check_eq("single_busy", bus4.busy, 1'b1);
    wait_until(t0 + 131);
    check_eq("single_cs_low_131", cs_n4, 1'b0);
    wait_until(t0 + 132);
    check_eq("single_cs_high_132", cs_n4, 1'b1);
    check_eq("single_done_132", bus4.done, 1'b1);
    check_eq("single_ready_132", bus4.req_ready, 1'b0);
    wait_until(t0 + 133);
    check_eq("single_done_133", bus4.done, 1'b0);
    wait_until(t0 + 136);
    check_eq("single_ready_136", bus4.req_ready, 1'b1);
    check_eq("single_busy_136", bus4.busy, 1'b0);
    @(posedge clk);
    check_eq("single_frame", frame_log[0][0], 16'h82A5);
    check_eq("single_rises", rises[0], 16);
    check_eq("single_cs_low_len", cs_low[0], 132);
    check_eq("single_done_cnt", done_cnt[0] - nd, 1);
    check_eq("single_done_t", done_t[0], 132);
    check_eq("single_rise0_t", rise_t[0][0], 4);
    check_eq("single_rise15_t", rise_t[0][15], 124);
    check_eq("single_stray", stray[0], 0);

    // Back-to-back with req_valid held: 0x00/0x11 then 0x04/0xFF.
    nf = frames[0];
    @(negedge clk);
    bus4.req_valid = 1'b1; bus4.req_addr = 7'h00; bus4.req_data = 8'h11;
    wait_ready(0, 1'b0, 10, "b2b_accept1");
    bus4.req_addr = 7'h04; bus4.req_data = 8'hFF;
    wait_ready(0, 1'b1, 200, "b2b_ready_back");
    wait_ready(0, 1'b0, 10, "b2b_accept2");
    bus4.req_valid = 1'b0;
    wait_frames(0, nf + 2, 400, "b2b_frames");
    @(posedge clk);
    check_eq("b2b_frame1", frame_log[0][nf % 8], 16'h8011);
    check_eq("b2b_frame2", frame_log[0][(nf + 1) % 8], 16'h84FF);
    check_eq("b2b_accept_gap", acc_gap[0], 136);
    check_eq("b2b_cs_high_ge4", cs_high[0] >= 4, 1'b1);

    // Input changes during a frame are ignored.
    repeat (10) @(negedge clk);
    nf = frames[0];
    na = accepts[0];
    bus4.req_valid = 1'b1; bus4.req_addr = 7'h33; bus4.req_data = 8'hC3;
    @(negedge clk);
    for (int i = 0; i < 125; i++) begin
      bus4.req_valid = 1'($urandom);
      bus4.req_addr  = 7'($urandom);
      bus4.req_data  = 8'($urandom);
      @(negedge clk);
    end
    bus4.req_valid = 1'b0;
    wait_frames(0, nf + 1, 300, "stab_frames");
    repeat (10) @(posedge clk);
    check_eq("stab_frame", frame_log[0][nf % 8], 16'hB3C3);
    check_eq("stab_single_accept", accepts[0] - na, 1);

    // Reset after 7 sclk rises, then a fresh write 0x7F/0x3C.
    @(negedge clk);
    bus4.req_valid = 1'b1; bus4.req_addr = 7'h55; bus4.req_data = 8'h66;
    @(negedge clk);
    bus4.req_valid = 1'b0;
    begin
      int n = 0;
      while (rises[0] < 7 && n < 300) begin
        @(posedge clk);
        n++;
      end
    end
    check_eq("mid_rises", rises[0], 7);
    #1 rst_n = 1'b0;
    #1;
    check_eq("mid_rst_cs_n", cs_n4, 1'b1);
    check_eq("mid_rst_sclk", sclk4, 1'b0);
    check_eq("mid_rst_copi", copi4, 1'b0);
    check_eq("mid_rst_ready", bus4.req_ready, 1'b1);
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    nf = frames[0];
    bus4.req_valid = 1'b1; bus4.req_addr = 7'h7F; bus4.req_data = 8'h3C;
    @(negedge clk);
    bus4.req_valid = 1'b0;
    wait_frames(0, nf + 1, 300, "post_rst_frames");
    @(posedge clk);
    check_eq("post_rst_frame", frame_log[0][nf % 8], 16'hFF3C);
    check_eq("post_rst_rises", rises[0], 16);
    check_eq("post_rst_cs_low", cs_low[0], 132);

    // CLK_DIV=6 instance: 0x01/0x5A -> 0x815A.
    @(negedge clk);
    bus6.req_valid = 1'b1; bus6.req_addr = 7'h01; bus6.req_data = 8'h5A;
    @(negedge clk);
    bus6.req_valid = 1'b0;
    @(posedge clk);
    t0 = e0[1];
    wait_until(t0 + 198);
    check_eq("div6_done_198", bus6.done, 1'b1);
    check_eq("div6_ready_198", bus6.req_ready, 1'b0);
    wait_until(t0 + 204);
    check_eq("div6_ready_204", bus6.req_ready, 1'b1);
    @(posedge clk);
    check_eq("div6_frame", frame_log[1][0], 16'h815A);
    check_eq("div6_rises", rises[1], 16);
    check_eq("div6_cs_low", cs_low[1], 198);
    for (int k = 0; k < 16; k++) begin
      check_eq($sformatf("div6_rise%0d_t", k), rise_t[1][k], 6 * (1 + 2 * k));
    end
    check_eq("div6_stray", stray[1], 0);
    check_eq("div4_stray_total", stray[0], 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected bench completion");
    $fatal(1, "bench timed out");
  end

endmodule
